// File: rtl/prog_loader.sv
// ============================================================================
// Module   : prog_loader
// Purpose  : Streams a program image into the CPU RAM, verifies its trailing
//            checksum and only then releases the CPU from halt.
// Revision : 1.0
// ============================================================================
`default_nettype none

module prog_loader #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load_req,
  input  logic              i_run_req,
  input  logic [7:0]        i_data_in,
  input  logic              i_data_valid,
  output logic              o_data_ready,
  output logic              o_ram_we,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic [7:0]        o_ram_wdata,
  output logic              o_cpu_halt,
  output logic              o_done,
  output logic              o_error
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_CHECK = 3'd2,
    S_RUN   = 3'd3,
    S_ERROR = 3'd4
  } state_t;

  localparam logic [ADDR_W-1:0] C_LAST_IDX = ADDR_W'(DEPTH - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_index;
  logic [ADDR_W-1:0] w_index_nxt;
  logic [7:0]        r_sum;
  logic [7:0]        w_sum_nxt;
  logic [7:0]        w_chk_total;
  logic              w_accept;
  logic              w_we_nxt;

  logic              r_ram_we;
  logic [ADDR_W-1:0] r_ram_addr;
  logic [7:0]        r_ram_wdata;
  logic              r_cpu_halt;
  logic              r_done;
  logic              r_error;

  assign o_data_ready = (r_state == S_LOAD) || (r_state == S_CHECK);
  assign w_accept     = i_data_valid && o_data_ready;
  assign w_chk_total  = r_sum + i_data_in;

  always_comb begin
    w_state_nxt = r_state;
    w_index_nxt = r_index;
    w_sum_nxt   = r_sum;
    w_we_nxt    = 1'b0;
    // A load request restarts from any state and drops a coincident byte.
    if (i_load_req) begin
      w_state_nxt = S_LOAD;
      w_index_nxt = '0;
      w_sum_nxt   = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_run_req) w_state_nxt = S_RUN;
        end
        S_LOAD: begin
          if (w_accept) begin
            w_we_nxt    = 1'b1;
            w_sum_nxt   = w_chk_total;
            w_index_nxt = r_index + 1'b1;
            if (r_index == C_LAST_IDX) w_state_nxt = S_CHECK;
          end
        end
        S_CHECK: begin
          if (w_accept) w_state_nxt = (w_chk_total == 8'd0) ? S_RUN : S_ERROR;
        end
        S_RUN, S_ERROR: ;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_index     <= '0;
      r_sum       <= '0;
      r_ram_we    <= 1'b0;
      r_ram_addr  <= '0;
      r_ram_wdata <= '0;
      r_cpu_halt  <= 1'b1;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_index    <= w_index_nxt;
      r_sum      <= w_sum_nxt;
      r_ram_we   <= w_we_nxt;
      if (w_we_nxt) begin
        r_ram_addr  <= r_index;
        r_ram_wdata <= i_data_in;
      end
      r_cpu_halt <= (w_state_nxt != S_RUN);
      r_done     <= (w_state_nxt == S_RUN);
      r_error    <= (w_state_nxt == S_ERROR);
    end
  end

  assign o_ram_we    = r_ram_we;
  assign o_ram_addr  = r_ram_addr;
  assign o_ram_wdata = r_ram_wdata;
  assign o_cpu_halt  = r_cpu_halt;
  assign o_done      = r_done;
  assign o_error     = r_error;

endmodule

`default_nettype wire

// File: tb/tb_prog_loader.sv
// ============================================================================
// Module   : tb_prog_loader
// Purpose  : Self-checking bench for prog_loader against an image-level model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_prog_loader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       load_req, run_req, data_valid;
  logic [7:0] data_in;
  logic       data_ready, ram_we, cpu_halt, done, error;
  logic [3:0] ram_addr;
  logic [7:0] ram_wdata;

  always #5 clk = ~clk;

  prog_loader #(.DEPTH(16), .ADDR_W(4)) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_load_req  (load_req),
    .i_run_req   (run_req),
    .i_data_in   (data_in),
    .i_data_valid(data_valid),
    .o_data_ready(data_ready),
    .o_ram_we    (ram_we),
    .o_ram_addr  (ram_addr),
    .o_ram_wdata (ram_wdata),
    .o_cpu_halt  (cpu_halt),
    .o_done      (done),
    .o_error     (error)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Image-level model: the bytes accepted since the last load request.
  bit         m_loading, m_running, m_err;
  logic [7:0] m_q[$];
  logic [7:0] m_ram[16];
  logic [7:0] obs_ram[16];
  bit         exp_we;
  logic [3:0] exp_addr;
  logic [7:0] exp_wdata;

  always @(posedge clk) if (ram_we) obs_ram[ram_addr] <= ram_wdata;

  function automatic logic [7:0] qsum();
    logic [7:0] s = 8'd0;
    foreach (m_q[i]) s = s + m_q[i];
    return s;
  endfunction

  task automatic model_reset();
    m_loading = 0; m_running = 0; m_err = 0; exp_we = 0;
    m_q.delete();
  endtask

  task automatic model_edge(input bit lr, input bit rr, input bit v, input logic [7:0] d);
    if (exp_we) m_ram[exp_addr] = exp_wdata;
    exp_we = 0;
    if (lr) begin
      m_loading = 1; m_running = 0; m_err = 0;
      m_q.delete();
    end else if (v && m_loading) begin
      if (m_q.size() < 16) begin
        exp_we = 1; exp_addr = 4'(m_q.size()); exp_wdata = d;
      end
      m_q.push_back(d);
      if (m_q.size() == 17) begin
        m_loading = 0;
        if (qsum() == 8'd0) m_running = 1;
        else m_err = 1;
      end
    end else if (rr && !m_loading && !m_running && !m_err) begin
      m_running = 1;
    end
  endtask

  task automatic post_checks();
    check("ram_we", 32'(ram_we), 32'(exp_we));
    if (exp_we) begin
      check("ram_addr", 32'(ram_addr), 32'(exp_addr));
      check("ram_wdata", 32'(ram_wdata), 32'(exp_wdata));
    end
    check("cpu_halt", 32'(cpu_halt), 32'(!m_running));
    check("done", 32'(done), 32'(m_running));
    check("error", 32'(error), 32'(m_err));
  endtask

  task automatic step(input bit lr, input bit rr, input bit v, input logic [7:0] d);
    load_req = lr; run_req = rr; data_valid = v; data_in = d;
    #1;
    check("data_ready", 32'(data_ready), 32'(m_loading));
    @(posedge clk);
    model_edge(lr, rr, v, d);
    #1;
    post_checks();
  endtask

  task automatic send_image(input logic [7:0] img[16], input logic [7:0] cks, input bit gap);
    step(1, 0, 0, 8'h00);
    for (int i = 0; i < 16; i++) begin
      step(0, 0, 1, img[i]);
      if (gap) step(0, 0, 0, 8'($urandom));
    end
    step(0, 0, 1, cks);
    step(0, 0, 0, 8'h00);
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_ram_we"}, 32'(ram_we), 32'd0);
    check({tag, "_ram_addr"}, 32'(ram_addr), 32'd0);
    check({tag, "_ram_wdata"}, 32'(ram_wdata), 32'd0);
    check({tag, "_cpu_halt"}, 32'(cpu_halt), 32'd1);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_error"}, 32'(error), 32'd0);
    check({tag, "_data_ready"}, 32'(data_ready), 32'd0);
  endtask

  logic [7:0] img[16];

  initial begin
    for (int i = 0; i < 16; i++) begin m_ram[i] = 8'h00; obs_ram[i] = 8'h00; end
    model_reset();
    rst_n = 1'b0;
    repeat (4) begin
      @(negedge clk);
      load_req = 1'($urandom); run_req = 1'($urandom);
      data_valid = 1'($urandom); data_in = 8'($urandom);
    end
    #1 reset_checks("rst");
    @(negedge clk);
    load_req = 0; run_req = 0; data_valid = 0; data_in = 8'h00;
    rst_n = 1'b1;
    #1 reset_checks("rst_rel");

    // Good image 0x00..0x0F with checksum 0x88, then run_req ignored in RUN.
    for (int i = 0; i < 16; i++) img[i] = 8'(i);
    send_image(img, 8'h88, 0);
    step(0, 1, 1, 8'h55);

    // Bad checksum, run_req ignored in ERROR, next load clears error.
    send_image(img, 8'h00, 0);
    step(0, 1, 0, 8'h00);

    // Gapped valid version of the good image.
    send_image(img, 8'h88, 1);

    // Abort with a coincident byte that must be dropped.
    step(1, 0, 0, 8'h00);
    for (int i = 0; i < 5; i++) step(0, 0, 1, 8'(8'hA0 + i));
    step(1, 0, 1, 8'hFF);
    for (int i = 0; i < 16; i++) step(0, 0, 1, 8'h10);
    step(0, 0, 1, 8'h00);
    step(0, 0, 0, 8'h00);

    // Asynchronous reset mid-load while a write strobe is pending.
    step(1, 0, 0, 8'h00);
    for (int i = 0; i < 8; i++) step(0, 0, 1, 8'(8'h50 + i));
    #2 rst_n = 1'b0;
    #1 reset_checks("midrst");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 1, 0, 8'h00);
    step(0, 0, 0, 8'h00);

    // Randomized traffic, with a correct checksum offered about half the time.
    for (int n = 0; n < 1500; n++) begin
      bit         lr, rr, v;
      logic [7:0] d;
      lr = (!m_loading && $urandom_range(3) == 0) || ($urandom_range(80) == 0);
      rr = ($urandom_range(15) == 0);
      v  = ($urandom_range(3) != 0);
      d  = (m_q.size() == 16 && $urandom_range(1) == 1) ? 8'(8'd0 - qsum()) : 8'($urandom);
      step(lr, rr, v, d);
    end
    step(0, 0, 0, 8'h00);
    step(0, 0, 0, 8'h00);

    for (int i = 0; i < 16; i++) check($sformatf("ram[%0d]", i), 32'(obs_ram[i]), 32'(m_ram[i]));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
